// File: rtl/vm1_irq_arbiter_if.sv
// CPU-side vectored interrupt bus (virq/istb/ivec/iack).
// The CPU is the master that strobes for a vector; the arbiter is the slave that answers.
interface vm1_irq_arbiter_if;
  logic        virq;
  logic        istb;
  logic [15:0] ivec;
  logic        iack;

  modport master (output istb, input virq, ivec, iack);
  modport slave  (input istb, output virq, ivec, iack);
endinterface

// File: rtl/vm1_irq_arbiter.sv
// Fixed-priority vectored interrupt arbiter: collects level requests, raises virq,
// and answers the CPU vector fetch with the winner's vector and a one-cycle irq_ack.
module vm1_irq_arbiter #(
  parameter int          N_IRQ    = 8,
  parameter logic [15:0] SPUR_VEC = 16'o000000
) (
  input  logic               clk_p,
  input  logic               rst,
  input  logic               init,
  input  logic [N_IRQ-1:0]   irq_req,
  input  logic [N_IRQ*7-1:0] irq_vec,
  output logic [N_IRQ-1:0]   irq_ack,
  vm1_irq_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    ACK  = 2'd2,
    GAP  = 2'd3
  } state_t;

  state_t             r_state;
  logic               r_virq;
  logic               r_iack;
  logic [15:0]        r_ivec;
  logic [N_IRQ-1:0]   r_irqAck;

  state_t             w_nextState;
  logic               w_nextVirq;
  logic               w_nextIack;
  logic [15:0]        w_nextIvec;
  logic [N_IRQ-1:0]   w_nextIrqAck;

  logic               w_anyReq;
  logic [6:0]         w_winVec;
  logic [N_IRQ-1:0]   w_winOneHot;

  // Scanning from the top down lets the lowest set index overwrite, giving index 0 priority.
  always_comb begin
    w_anyReq    = |irq_req;
    w_winVec    = '0;
    w_winOneHot = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (irq_req[i]) begin
        w_winVec       = irq_vec[7*i +: 7];
        w_winOneHot    = '0;
        w_winOneHot[i] = 1'b1;
      end
    end
  end

  always_comb begin
    w_nextState  = r_state;
    w_nextVirq   = r_virq;
    w_nextIack   = r_iack;
    w_nextIvec   = r_ivec;
    w_nextIrqAck = '0;
    case (r_state)
      IDLE: begin
        w_nextVirq = 1'b0;
        if (w_anyReq) begin
          w_nextState = REQ;
          w_nextVirq  = 1'b1;
        end
      end
      REQ: begin
        // A strobe wins over a same-cycle withdrawal; with nothing pending it gets the spurious vector.
        if (bus.istb) begin
          w_nextState = ACK;
          w_nextVirq  = 1'b0;
          w_nextIack  = 1'b1;
          if (w_anyReq) begin
            w_nextIvec   = {7'b0, w_winVec, 2'b00};
            w_nextIrqAck = w_winOneHot;
          end else begin
            w_nextIvec = SPUR_VEC;
          end
        end else if (!w_anyReq) begin
          w_nextState = IDLE;
          w_nextVirq  = 1'b0;
        end else begin
          w_nextVirq = 1'b1;
        end
      end
      ACK: begin
        w_nextVirq = 1'b0;
        if (!bus.istb) begin
          w_nextState = GAP;
          w_nextIack  = 1'b0;
          w_nextIvec  = '0;
        end
      end
      GAP: begin
        w_nextState = IDLE;
        w_nextVirq  = 1'b0;
        w_nextIack  = 1'b0;
        w_nextIvec  = '0;
      end
      default: begin
        w_nextState = IDLE;
        w_nextVirq  = 1'b0;
        w_nextIack  = 1'b0;
        w_nextIvec  = '0;
      end
    endcase
  end

  // init is the bus-level reset: same clearing as rst, but only at the clock edge.
  always_ff @(posedge clk_p or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_virq   <= 1'b0;
      r_iack   <= 1'b0;
      r_ivec   <= '0;
      r_irqAck <= '0;
    end else if (init) begin
      r_state  <= IDLE;
      r_virq   <= 1'b0;
      r_iack   <= 1'b0;
      r_ivec   <= '0;
      r_irqAck <= '0;
    end else begin
      r_state  <= w_nextState;
      r_virq   <= w_nextVirq;
      r_iack   <= w_nextIack;
      r_ivec   <= w_nextIvec;
      r_irqAck <= w_nextIrqAck;
    end
  end

  assign bus.virq = r_virq;
  assign bus.iack = r_iack;
  assign bus.ivec = r_ivec;
  assign irq_ack  = r_irqAck;

endmodule

// File: tb/tb_vm1_irq_arbiter.sv
// Directed bench for vm1_irq_arbiter with four devices; every task checks its own
// expectations inline against hand-computed vectors.
module tb_vm1_irq_arbiter;

  localparam int N = 4;

  logic          clk_p = 1'b0;
  logic          rst   = 1'b0;
  logic          init  = 1'b0;
  logic [N-1:0]  irq_req = '0;
  logic [N*7-1:0] irq_vec;
  logic [N-1:0]  irq_ack;

  int testsRun    = 0;
  int testsFailed = 0;

  // Device vectors 060, 064, 0100, 0300 expressed as bits [8:2].
  localparam logic [N*7-1:0] VECS = {7'd48, 7'd16, 7'd13, 7'd12};

  vm1_irq_arbiter_if bus ();

  vm1_irq_arbiter #(.N_IRQ(N), .SPUR_VEC(16'o000000)) dut (
    .clk_p   (clk_p),
    .rst     (rst),
    .init    (init),
    .irq_req (irq_req),
    .irq_vec (irq_vec),
    .irq_ack (irq_ack),
    .bus     (bus.slave)
  );

  always #5 clk_p = ~clk_p;

  task automatic tick();
    @(posedge clk_p);
    #1;
  endtask

  // CPU side of one vector fetch; the device drops whichever request got irq_ack.
  task automatic applyStimulus(output logic timedOut, output logic [15:0] gotVec,
                               output logic gotIack, output logic [N-1:0] gotAck,
                               output logic gapVirq);
    timedOut = 1'b1;
    for (int k = 0; k < 10; k++) begin
      if (bus.virq) begin
        timedOut = 1'b0;
        break;
      end
      tick();
    end
    bus.istb = 1'b1;
    tick();
    gotVec  = bus.ivec;
    gotIack = bus.iack;
    gotAck  = irq_ack;
    irq_req = irq_req & ~irq_ack;
    tick();
    bus.istb = 1'b0;
    tick();
    gapVirq = bus.virq;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2;
    testsRun++;
    if ({bus.virq, bus.iack, bus.ivec, irq_ack} !== 22'b0) begin
      testsFailed++;
      $display("[TB] FAIL reset_outputs got virq=%b iack=%b ivec=%o ack=%b required all 0",
               bus.virq, bus.iack, bus.ivec, irq_ack);
    end
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    irq_req = 4'b0100;
    tick();
    testsRun++;
    if (bus.virq !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL basic_virq got %b required 1", bus.virq);
    end
    bus.istb = 1'b1;
    tick();
    testsRun++;
    if (bus.ivec !== 16'o000100 || bus.iack !== 1'b1 || irq_ack !== 4'b0100) begin
      testsFailed++;
      $display("[TB] FAIL basic_fetch got ivec=%o iack=%b ack=%b required 000100 1 0100",
               bus.ivec, bus.iack, irq_ack);
    end
    irq_req = 4'b0000;
    irq_vec[20:14] = 7'd99;
    tick();
    testsRun++;
    if (bus.ivec !== 16'o000100 || bus.iack !== 1'b1 || irq_ack !== 4'b0000 || bus.virq !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL basic_hold got ivec=%o iack=%b ack=%b virq=%b required 000100 1 0000 0",
               bus.ivec, bus.iack, irq_ack, bus.virq);
    end
    irq_vec = VECS;
    bus.istb = 1'b0;
    tick();
    testsRun++;
    if (bus.ivec !== 16'o0 || bus.iack !== 1'b0 || bus.virq !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL basic_release got ivec=%o iack=%b virq=%b required 0 0 0",
               bus.ivec, bus.iack, bus.virq);
    end
    tick();
  endtask

  task automatic test_preempt();
    logic to, ia, gv;
    logic [15:0] v;
    logic [N-1:0] a;
    irq_req = 4'b1000;
    tick();
    irq_req = 4'b1010;
    tick();
    testsRun++;
    if (bus.virq !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL preempt_no_glitch got virq=%b required 1", bus.virq);
    end
    applyStimulus(to, v, ia, a, gv);
    testsRun++;
    if (to || v !== 16'o000064 || ia !== 1'b1 || a !== 4'b0010) begin
      testsFailed++;
      $display("[TB] FAIL preempt_winner got to=%b ivec=%o iack=%b ack=%b required 0 000064 1 0010",
               to, v, ia, a);
    end
    applyStimulus(to, v, ia, a, gv);
    testsRun++;
    if (to || v !== 16'o000300 || a !== 4'b1000 || gv !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL preempt_dev3 got to=%b ivec=%o ack=%b gapvirq=%b required 0 000300 1000 0",
               to, v, a, gv);
    end
  endtask

  task automatic test_withdraw();
    irq_req = 4'b0001;
    tick();
    irq_req = 4'b0000;
    tick();
    testsRun++;
    if (bus.virq !== 1'b0 || irq_ack !== 4'b0 || bus.iack !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL withdraw got virq=%b ack=%b iack=%b required 0 0000 0",
               bus.virq, irq_ack, bus.iack);
    end
  endtask

  task automatic test_spurious();
    irq_req = 4'b0001;
    tick();
    irq_req  = 4'b0000;
    bus.istb = 1'b1;
    tick();
    testsRun++;
    if (bus.iack !== 1'b1 || bus.ivec !== 16'o0 || irq_ack !== 4'b0) begin
      testsFailed++;
      $display("[TB] FAIL spurious got iack=%b ivec=%o ack=%b required 1 0 0000",
               bus.iack, bus.ivec, irq_ack);
    end
    tick();
    bus.istb = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_back_to_back();
    logic to, ia, gv;
    logic [15:0] v;
    logic [N-1:0] a;
    logic [15:0] expVec [4];
    expVec[0] = 16'o000060;
    expVec[1] = 16'o000064;
    expVec[2] = 16'o000100;
    expVec[3] = 16'o000300;
    irq_req = 4'b1111;
    for (int d = 0; d < 4; d++) begin
      applyStimulus(to, v, ia, a, gv);
      testsRun++;
      if (to || v !== expVec[d] || ia !== 1'b1 || a !== (4'b0001 << d) || gv !== 1'b0) begin
        testsFailed++;
        $display("[TB] FAIL b2b_dev%0d got to=%b ivec=%o iack=%b ack=%b gapvirq=%b required ivec=%o ack=%b",
                 d, to, v, ia, a, gv, expVec[d], 4'b0001 << d);
      end
    end
    testsRun++;
    if (irq_req !== 4'b0 || bus.virq !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL b2b_drain got req=%b virq=%b required 0000 0", irq_req, bus.virq);
    end
  endtask

  task automatic test_abort();
    logic to, ia, gv;
    logic [15:0] v;
    logic [N-1:0] a;
    for (int pass = 0; pass < 2; pass++) begin
      irq_req = 4'b0100;
      tick();
      bus.istb = 1'b1;
      tick();
      irq_req = 4'b0000;
      tick();
      if (pass == 0) begin
        #2 rst = 1'b1;
        #1;
      end else begin
        init = 1'b1;
        tick();
      end
      testsRun++;
      if (bus.iack !== 1'b0 || bus.virq !== 1'b0 || bus.ivec !== 16'o0) begin
        testsFailed++;
        $display("[TB] FAIL abort%0d_clear got iack=%b virq=%b ivec=%o required 0 0 0",
                 pass, bus.iack, bus.virq, bus.ivec);
      end
      tick();
      rst  = 1'b0;
      init = 1'b0;
      tick();
      tick();
      testsRun++;
      if (bus.iack !== 1'b0) begin
        testsFailed++;
        $display("[TB] FAIL abort%0d_no_iack got iack=%b required 0", pass, bus.iack);
      end
      bus.istb = 1'b0;
      tick();
    end
    irq_req = 4'b0010;
    applyStimulus(to, v, ia, a, gv);
    testsRun++;
    if (to || v !== 16'o000064 || a !== 4'b0010) begin
      testsFailed++;
      $display("[TB] FAIL abort_recover got to=%b ivec=%o ack=%b required 0 000064 0010", to, v, a);
    end
  endtask

  task automatic test_idle_istb();
    irq_req  = 4'b0000;
    bus.istb = 1'b1;
    tick();
    tick();
    testsRun++;
    if (bus.iack !== 1'b0 || bus.virq !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL idle_istb got iack=%b virq=%b required 0 0", bus.iack, bus.virq);
    end
    bus.istb = 1'b0;
    tick();
  endtask

  initial begin
    bus.istb = 1'b0;
    irq_vec  = VECS;
    test_reset();
    test_basic();
    test_preempt();
    test_withdraw();
    test_spurious();
    test_back_to_back();
    test_abort();
    test_idle_istb();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
